// File: rtl/lamp_pkg.sv
// lamp_pkg: shared constants for the room-lamp occupancy front end
package lamp_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_DEF = 16;
  localparam logic [7:0] GLITCH_MAX = 8'hFF;
endpackage

// File: rtl/beam_debounce_ch.sv
// beam_debounce_ch: one beam channel -- synchroniser, debounce counter, level and rise/abort strobes
module beam_debounce_ch
  import lamp_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic abort
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] c;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  // sync raw, count a differing level to acceptance, abort and flag when it reverts early
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      c <= '0;
      lvl <= 1'b0;
      rise <= 1'b0;
      abort <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      abort <= 1'b0;
      if (s != lvl) begin
        if (c == LAST) begin
          lvl <= s;
          c <= '0;
          rise <= s;
        end else begin
          c <= c + 1'b1;
        end
      end else if (c != '0) begin
        c <= '0;
        abort <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/beam_sensor_conditioner.sv
// beam_sensor_conditioner: debounced beam events arbitrated into single-cycle x1/x2 pulses plus glitch diagnostics
module beam_sensor_conditioner
  import lamp_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw1,
  input  logic       raw2,
  output logic       x1,
  output logic       x2,
  output logic       lvl1,
  output logic       lvl2,
  output logic [7:0] glitch_cnt
);
  logic rise1, rise2, ab1, ab2, p1, p2, want1, want2;
  logic [8:0] gsum;
  logic [7:0] gnext;
  beam_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_ch1 (
    .clk(clk), .rst(rst), .raw(raw1), .lvl(lvl1), .rise(rise1), .abort(ab1)
  );
  beam_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_ch2 (
    .clk(clk), .rst(rst), .raw(raw2), .lvl(lvl2), .rise(rise2), .abort(ab2)
  );
  // pending requests and the saturating glitch sum
  always_comb begin
    want1 = p1 | rise1;
    want2 = p2 | rise2;
    gsum = {1'b0, glitch_cnt} + 9'(ab1) + 9'(ab2);
    gnext = (gsum > 9'(GLITCH_MAX)) ? GLITCH_MAX : gsum[7:0];
  end
  // channel 1 wins a tie; the loser stays pending and goes out on the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
      x1 <= 1'b0;
      x2 <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      x1 <= want1;
      x2 <= want2 & ~want1;
      p1 <= 1'b0;
      p2 <= want2 & want1;
      glitch_cnt <= gnext;
    end
  end
endmodule
